// File: rtl/dmem_load_unit_if.sv
// Pipeline-side request/response and read-bus signals of the data-memory load unit.
// The load unit takes the master modport; the pipeline/bus environment takes slave.
interface dmem_load_unit_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_fun3;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall_o;

  logic        bus_stb;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        misaligned;
  logic        fault;

  modport master (
    input  req_valid, req_addr, req_fun3, req_rd, flush,
    input  bus_rdata, bus_ack, bus_err,
    output stall_o, bus_stb, bus_addr, bus_sel,
    output rsp_valid, rsp_data, rsp_rd, misaligned, fault
  );

  modport slave (
    output req_valid, req_addr, req_fun3, req_rd, flush,
    output bus_rdata, bus_ack, bus_err,
    input  stall_o, bus_stb, bus_addr, bus_sel,
    input  rsp_valid, rsp_data, rsp_rd, misaligned, fault
  );
endinterface

// File: rtl/dmem_load_unit.sv
// RV32I load unit: single-beat bus read, lane extraction with sign/zero extension,
// misalignment / illegal-encoding / bus-error / timeout detection, pipeline stall.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a MEM-stage load; decodes and latches it on accept
// S_WAIT | bus strobe asserted, counting down toward timeout
// S_RESP | one-cycle report of data, misaligned or fault (unless killed)
module dmem_load_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_load_unit_if.master lsu
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    R_DATA  = 2'd0,
    R_MISAL = 2'd1,
    R_FAULT = 2'd2
  } rkind_t;

  // Down-counter is loaded with MAX_WAIT-1 so terminal count 0 is the last strobe cycle.
  localparam logic [7:0] WAIT_LOAD = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  rkind_t      kind_q, kind_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  fun3_q, fun3_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;

  logic        accept;
  logic        resp_live;

  function automatic logic fun3_legal(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: fun3_legal = 1'b1;
      default:                      fun3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd1, 3'd5: addr_misaligned = off[0];
      3'd2:       addr_misaligned = (off != 2'b00);
      default:    addr_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0, 3'd4: lane_sel = 4'b0001 << off;
      3'd1, 3'd5: lane_sel = 4'b0011 << {off[1], 1'b0};
      default:    lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    extract = {{24{b[7]}}, b};
      3'd4:    extract = {24'b0, b};
      3'd1:    extract = {{16{h[15]}}, h};
      3'd5:    extract = {16'b0, h};
      default: extract = d;
    endcase
  endfunction

  assign accept = (state_q == S_IDLE) && lsu.req_valid && !lsu.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      kind_q   <= R_DATA;
      addr_q   <= '0;
      fun3_q   <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      kill_q   <= 1'b0;
      data_q   <= '0;
      rsp_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      addr_q   <= addr_d;
      fun3_q   <= fun3_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      kill_q   <= kill_d;
      data_q   <= data_d;
      rsp_rd_q <= rsp_rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    addr_d   = addr_q;
    fun3_d   = fun3_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    kill_d   = kill_q;
    data_d   = data_q;
    rsp_rd_d = rsp_rd_q;

    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (accept) begin
          addr_d = lsu.req_addr;
          fun3_d = lsu.req_fun3;
          rd_d   = lsu.req_rd;
          if (!fun3_legal(lsu.req_fun3)) begin
            kind_d  = R_FAULT;
            state_d = S_RESP;
          end else if (addr_misaligned(lsu.req_fun3, lsu.req_addr[1:0])) begin
            kind_d  = R_MISAL;
            state_d = S_RESP;
          end else begin
            kind_d  = R_DATA;
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // A flush only marks the load dead; the bus cycle must still terminate cleanly.
        if (lsu.flush) begin
          kill_d = 1'b1;
        end
        if (lsu.bus_err) begin
          kind_d  = R_FAULT;
          state_d = S_RESP;
        end else if (lsu.bus_ack) begin
          kind_d   = R_DATA;
          data_d   = extract(fun3_q, addr_q[1:0], lsu.bus_rdata);
          rsp_rd_d = rd_q;
          state_d  = S_RESP;
        end else if (cnt_q == 8'd0) begin
          kind_d  = R_FAULT;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_RESP: begin
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign resp_live = (state_q == S_RESP) && !kill_q && !lsu.flush;

  assign lsu.stall_o    = accept || (state_q == S_WAIT);
  assign lsu.bus_stb    = (state_q == S_WAIT);
  assign lsu.bus_addr   = (state_q == S_WAIT) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign lsu.bus_sel    = (state_q == S_WAIT) ? lane_sel(fun3_q, addr_q[1:0]) : 4'h0;
  assign lsu.rsp_valid  = resp_live && (kind_q == R_DATA);
  assign lsu.misaligned = resp_live && (kind_q == R_MISAL);
  assign lsu.fault      = resp_live && (kind_q == R_FAULT);
  assign lsu.rsp_data   = data_q;
  assign lsu.rsp_rd     = rsp_rd_q;

endmodule

// File: doc/dmem_load_unit.md
# dmem_load_unit

- Load-side data-memory interface for the pipelined RV32I core; read counterpart of the store path.
- Accepts one load per request from the MEM stage and runs a single-beat bus read with an ack/err handshake.
- Extracts and sign- or zero-extends the addressed byte, halfword or word, returns it with its destination register, and stalls the pipeline meanwhile.
- Detects misaligned addresses, illegal load encodings and bus timeouts.

## Interface
- MAX_WAIT, 255: bus cycles allowed in WAIT before a timeout fault; legal range 1..255; 8-bit counter.
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM-stage load request; held stable by the pipeline while stall_o=1.
- req_addr  in  32  byte address.
- req_fun3  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; 3/6/7 illegal.
- req_rd  in  5  destination register.
- flush  in  1  kill the current or pending load.
- stall_o  out  1  freeze pipeline.
- bus_stb  out  1  read strobe.
- bus_addr  out  32  word address: {req_addr[31:2],2'b00}.
- bus_sel  out  4  byte-lane select.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  read complete.
- bus_err  in  1  bus error; terminates the cycle.
- rsp_valid  out  1  one-cycle pulse: rsp_data/rsp_rd valid.
- rsp_data  out  32  extended load result.
- rsp_rd  out  5  destination register of the result.
- misaligned  out  1  one-cycle pulse: misaligned load.
- fault  out  1  one-cycle pulse: illegal fun3, bus_err or timeout.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, req_valid=1, flush=0:
  - Latch addr/fun3/rd.
  - Illegal fun3 → RESP with fault flag.
  - Misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]≠0) → RESP with misaligned flag.
  - Otherwise → WAIT.
- IDLE with flush=1: request ignored, stay IDLE.
- WAIT:
  - bus_stb=1; bus_addr and bus_sel come from latched values.
  - bus_sel: LB/LBU 4'b0001<<addr[1:0]; LH/LHU 4'b0011<<{addr[1],1'b0}; LW 4'b1111.
  - bus_ack=1 → capture extracted data → RESP.
  - bus_err=1 (priority over ack) → fault flag → RESP.
  - Wait counter reaches MAX_WAIT with no ack/err → fault flag → RESP.
- Extraction: select lane by addr[1:0]; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes 32 bits.
- RESP: exactly one of rsp_valid, misaligned or fault pulses for one cycle, unless killed; then → IDLE unconditionally. req_valid is ignored in RESP; the held instruction advances at the end of RESP.
- Flush in WAIT sets a kill flag: the bus cycle still completes (ack/err/timeout), but RESP produces no pulse. Flush in RESP suppresses that cycle's pulse.
- stall_o = (IDLE & req_valid & ~flush) | WAIT. Combinational and low in RESP.
- rsp_data/rsp_rd hold their last captured value between responses.

## Timing
- Reset values:
  - State IDLE, counter 0, kill flag 0.
  - stall_o=0 while req_valid=0; bus_stb=0, bus_sel=0, bus_addr=0.
  - rsp_valid=0, rsp_data=0, rsp_rd=0, misaligned=0, fault=0.
- Reset mid-operation: bus_stb drops asynchronously; no response is issued after release.
- Zero-wait ack (ack in the first WAIT cycle): request seen at cycle 0, stb at cycle 1, rsp_valid at cycle 2. Minimum 3 cycles per load, so back-to-back loads issue every 3 cycles.
- Each extra ack delay adds one cycle.
- Misaligned and illegal loads: pulse at cycle 1, no bus activity.
- Timeout: stb high for exactly MAX_WAIT cycles, then fault in the next cycle.
- Ack and err in the same cycle: fault, no rsp_valid.

## Test plan
- LW addr 0x100, bus_rdata 0xDEADBEEF, ack in first WAIT cycle → bus_sel 4'b1111, bus_addr 0x100; cycle 2 rsp_valid, rsp_data 0xDEADBEEF, rsp_rd echoed; stall_o high cycles 0-1.
- Byte and halfword extraction, bus_rdata 0x80F17F82:
  - LB addr 0x103 → bus_sel 4'b1000, rsp_data 0xFFFFFF80.
  - LBU addr 0x101 → rsp_data 0x0000007F.
  - LH addr 0x102 → bus_sel 4'b1100, rsp_data 0xFFFF80F1.
  - LHU addr 0x100 → rsp_data 0x00007F82.
- Misaligned and illegal encodings:
  - LW addr 0x102 → misaligned pulse at cycle 1, bus_stb never high, no rsp_valid.
  - fun3=3 → fault pulse, no bus cycle.
- Bus errors and timeout:
  - ack withheld, MAX_WAIT=4 → stb high for 4 cycles, then fault pulse.
  - ack and err together → fault only.
- Flush asserted mid-WAIT, ack 3 cycles later → no rsp_valid/fault; IDLE after RESP; next load completes normally.
- reset_n low during WAIT → bus_stb 0 immediately, all outputs at reset values; first load after release completes in 3 cycles.
